// File: rtl/subtractor_64_seq_if.sv
// Operand/result handshake bundle for subtractor_64_seq.
// The ovf wire exists only when SUB_OVF_FLAG_EN is defined.
interface subtractor_64_seq_if #(
  parameter int unsigned WIDTH = 64
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SUB_OVF_FLAG_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, in1, in2, bin, out_ready,
`ifdef SUB_OVF_FLAG_EN
    input  ovf,
`endif
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, in1, in2, bin, out_ready,
`ifdef SUB_OVF_FLAG_EN
    output ovf,
`endif
    output in_ready, out_valid, diff, bout
  );
endinterface

// File: rtl/subtractor_64_seq.sv
// Multi-cycle ripple-borrow subtractor: diff = in1 - in2 - bin, one CHUNK slice per cycle.
// Optional signed-overflow flag enabled by defining SUB_OVF_FLAG_EN.
module subtractor_64_seq #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16
) (
  input logic                clk,
  input logic                rst_n,
  subtractor_64_seq_if.slave bus
);
  localparam int unsigned NumChunks = WIDTH / CHUNK;
  localparam int unsigned IdxW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                             state_q, state_d;
  logic [IdxW-1:0]                    idx_q, idx_d;
  logic [NumChunks-1:0][CHUNK-1:0]    a_q, a_d;
  logic [NumChunks-1:0][CHUNK-1:0]    b_q, b_d;
  logic [NumChunks-1:0][CHUNK-1:0]    diff_q, diff_d;
  logic                               borrow_q, borrow_d;
  logic                               bout_q, bout_d;
  logic                               in_ready_q, in_ready_d;
  logic                               out_valid_q, out_valid_d;
`ifdef SUB_OVF_FLAG_EN
  logic                               ovf_q, ovf_d;
`endif
  logic [CHUNK:0]                     slice_res;

  // Top bit of the (CHUNK+1)-bit result is the borrow out of this slice.
  always_comb begin
    slice_res = {1'b0, a_q[idx_q]} - {1'b0, b_q[idx_q]} - {{CHUNK{1'b0}}, borrow_q};
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    diff_d      = diff_q;
    borrow_d    = borrow_q;
    bout_d      = bout_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef SUB_OVF_FLAG_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d        = bus.in1;
          b_d        = bus.in2;
          borrow_d   = bus.bin;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = StRun;
        end
      end
      StRun: begin
        diff_d[idx_q] = slice_res[CHUNK-1:0];
        borrow_d      = slice_res[CHUNK];
        idx_d         = idx_q + 1'b1;
        if (idx_q == IdxW'(NumChunks - 1)) begin
          bout_d      = slice_res[CHUNK];
`ifdef SUB_OVF_FLAG_EN
          // Two's-complement overflow: operand signs differ and result sign differs from in1.
          ovf_d       = (a_q[NumChunks-1][CHUNK-1] != b_q[NumChunks-1][CHUNK-1]) &&
                        (slice_res[CHUNK-1] != a_q[NumChunks-1][CHUNK-1]);
`endif
          idx_d       = '0;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        // in_ready rises one cycle later, so nothing is accepted on this edge.
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      bout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      diff_q      <= diff_d;
      borrow_q    <= borrow_d;
      bout_q      <= bout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef SUB_OVF_FLAG_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
`ifdef SUB_OVF_FLAG_EN
  assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_subtractor_64_seq.sv
// Self-checking bench for subtractor_64_seq: directed corner cases plus random operands.
// Checks ovf as well when built with SUB_OVF_FLAG_EN.
module tb_subtractor_64_seq;
  localparam int unsigned Width = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  subtractor_64_seq_if #(.WIDTH(Width)) bus ();

  subtractor_64_seq #(
    .WIDTH (Width),
    .CHUNK (16)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {bout, ovf, diff} from plain arithmetic on the operands.
  function automatic logic [65:0] ref_sub(input logic [63:0] a, input logic [63:0] b,
                                          input logic bi);
    logic [63:0] d;
    logic [64:0] need;
    logic        bo;
    logic        ov;
    d    = a - b - 64'(bi);
    need = {1'b0, b} + 65'(bi);
    bo   = ({1'b0, a} < need);
    ov   = (a[63] != b[63]) && (d[63] != a[63]);
    return {bo, ov, d};
  endfunction

  function automatic logic [63:0] pick_operand();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0:       v = 64'h0;
      1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      2:       v = 64'h8000_0000_0000_0000;
      3:       v = 64'($urandom_range(0, 3));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "/out_valid"}, 64'(bus.out_valid), 64'd0);
    check_eq({tag, "/in_ready"}, 64'(bus.in_ready), 64'd1);
    check_eq({tag, "/diff"}, bus.diff, 64'd0);
    check_eq({tag, "/bout"}, 64'(bus.bout), 64'd0);
`ifdef SUB_OVF_FLAG_EN
    check_eq({tag, "/ovf"}, 64'(bus.ovf), 64'd0);
`endif
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "/in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic bi,
                        input int stall, input string tag);
    logic [65:0] exp;
    int          lat;
    exp = ref_sub(a, b, bi);
    wait_ready(tag);
    bus.in_valid = 1'b1;
    bus.in1      = a;
    bus.in2      = b;
    bus.bin      = bi;
    @(negedge clk);
    // Operands change right after acceptance; the result must not follow them.
    bus.in_valid = 1'b0;
    bus.in1      = {$urandom, $urandom};
    bus.in2      = {$urandom, $urandom};
    bus.bin      = 1'($urandom);
    check_eq({tag, "/busy"}, 64'(bus.in_ready), 64'd0);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "/latency"}, 64'(lat), 64'd4);
    check_eq({tag, "/diff"}, bus.diff, exp[63:0]);
    check_eq({tag, "/bout"}, 64'(bus.bout), 64'(exp[65]));
`ifdef SUB_OVF_FLAG_EN
    check_eq({tag, "/ovf"}, 64'(bus.ovf), 64'(exp[64]));
`endif
    for (int i = 0; i < stall; i++) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in1       = {$urandom, $urandom};
      bus.in2       = {$urandom, $urandom};
      @(negedge clk);
      check_eq({tag, "/hold_valid"}, 64'(bus.out_valid), 64'd1);
      check_eq({tag, "/hold_ready"}, 64'(bus.in_ready), 64'd0);
      check_eq({tag, "/hold_diff"}, bus.diff, exp[63:0]);
      check_eq({tag, "/hold_bout"}, 64'(bus.bout), 64'(exp[65]));
    end
    // in_valid stays high across the DONE->IDLE edge and must not be taken.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check_eq({tag, "/drop_valid"}, 64'(bus.out_valid), 64'd0);
    check_eq({tag, "/idle_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    run_op(64'h0, 64'h0, 1'b0, 0, "zero");
    run_op(64'd3, 64'd1, 1'b1, 0, "three_minus_one");
    run_op(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 1, "aa_minus_55");
    run_op(64'h0, 64'h1, 1'b0, 0, "ripple_wrap");
    run_op(64'h0, 64'h0, 1'b1, 0, "bin_wrap");
    run_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 0, "signed_ovf");
    run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 3, "stall_done");
    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 0, "after_stall");

    // Reset while slice 2 is about to be processed.
    wait_ready("mid_reset");
    bus.in_valid = 1'b1;
    bus.in1      = 64'hDEAD_BEEF_0000_0001;
    bus.in2      = 64'hFFFF_0000_FFFF_0000;
    bus.bin      = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("mid_reset/no_valid", 64'(bus.out_valid), 64'd0);
    end
    check_reset_outputs("mid_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("mid_reset/stays_quiet", 64'(bus.out_valid), 64'd0);
    end
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, "ones_minus_ones");

    for (int i = 0; i < 40; i++) begin
      run_op(pick_operand(), pick_operand(), 1'($urandom), $urandom_range(0, 2), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
